// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator for decode, behind a two-slot skid buffer.
// The immediate is decoded as the instruction enters, so both slots hold finished results.
module imm_gen_pipe #(
    parameter int XLEN           = 64,
    parameter int TAG_W          = 5,
    parameter bit BR_BYTE_OFFSET = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instr,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_imm,
    output logic [2:0]       o_fmt,
    output logic             o_no_imm,
    output logic [TAG_W-1:0] o_tag
);

    localparam logic [6:0] OP_IMM_ARITH = 7'b0010011;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;

    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_SRXI = 3'b101;

    typedef enum logic [2:0] {
        FMT_NONE    = 3'd0,
        FMT_I       = 3'd1,
        FMT_I_SHAMT = 3'd2,
        FMT_S       = 3'd3,
        FMT_SB      = 3'd4,
        FMT_U       = 3'd5,
        FMT_UJ      = 3'd6
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             no_imm;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // ------------------------------------------------------------------
    // Decode: everything is built 64 bits wide and sign extended there,
    // then cut to XLEN, which is the same as extending straight to XLEN.
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        sbit;
    logic [63:0] dec_imm64;
    fmt_e        dec_fmt;
    logic        dec_no_imm;
    entry_t      dec_entry;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign sbit   = i_instr[31];

    always_comb begin
        dec_imm64  = '0;
        dec_fmt    = FMT_NONE;
        dec_no_imm = 1'b0;
        case (opcode)
            OP_IMM_ARITH: begin
                if (funct3 == F3_SLLI || funct3 == F3_SRXI) begin
                    dec_fmt = FMT_I_SHAMT;
                    if (XLEN == 64) begin
                        dec_imm64 = {58'd0, i_instr[25:20]};
                    end else begin
                        dec_imm64 = {59'd0, i_instr[24:20]};
                    end
                end else begin
                    dec_fmt   = FMT_I;
                    dec_imm64 = {{52{sbit}}, i_instr[31:20]};
                end
            end
            OP_JALR, OP_LOAD: begin
                dec_fmt   = FMT_I;
                dec_imm64 = {{52{sbit}}, i_instr[31:20]};
            end
            OP_STORE: begin
                dec_fmt   = FMT_S;
                dec_imm64 = {{52{sbit}}, i_instr[31:25], i_instr[11:7]};
            end
            OP_BRANCH: begin
                dec_fmt = FMT_SB;
                if (BR_BYTE_OFFSET) begin
                    dec_imm64 = {{52{sbit}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
                end else begin
                    dec_imm64 = {{53{sbit}}, i_instr[7], i_instr[30:25], i_instr[11:8]};
                end
            end
            OP_LUI, OP_AUIPC: begin
                dec_fmt   = FMT_U;
                dec_imm64 = {{33{sbit}}, i_instr[30:12], 12'd0};
            end
            OP_JAL: begin
                dec_fmt = FMT_UJ;
                if (BR_BYTE_OFFSET) begin
                    dec_imm64 = {{44{sbit}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
                end else begin
                    dec_imm64 = {{45{sbit}}, i_instr[19:12], i_instr[20], i_instr[30:21]};
                end
            end
            default: begin
                dec_no_imm = 1'b1;
            end
        endcase
    end

    assign dec_entry.imm    = dec_imm64[XLEN-1:0];
    assign dec_entry.fmt    = dec_fmt;
    assign dec_entry.no_imm = dec_no_imm;
    assign dec_entry.tag    = i_tag;

    // ------------------------------------------------------------------
    // Handshake: a beat moves on a rising edge where valid and ready are
    // both high on that side. o_ready comes straight from the state
    // register (low only when the skid slot is occupied), so it never
    // depends combinationally on i_ready. Flush empties both slots and
    // drops whatever is offered in the same cycle.
    // ------------------------------------------------------------------
    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   accept;

    assign o_ready = (state_q != ST_FULL);
    assign o_valid = (state_q != ST_EMPTY);
    assign accept  = i_valid && o_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = dec_entry;
                    end
                end
                ST_ONE: begin
                    if (accept && i_ready) begin
                        main_d = dec_entry;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        skid_d  = dec_entry;
                    end else if (i_ready) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (i_ready) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign o_imm    = main_q.imm;
    assign o_fmt    = main_q.fmt;
    assign o_no_imm = main_q.no_imm;
    assign o_tag    = main_q.tag;

endmodule
